multiplier_pl_tree: RTL

- Parametrised, fully pipelined unsigned/signed integer multiplier.
- Generates WIDTH partial products, then reduces them pairwise through a registered adder tree of log2(WIDTH) levels.
- Accepts one operand pair per cycle with valid/ready handshakes at both ends.
- Calculator datapath block for wider operands and back-pressured consumers; supersedes the fixed 4-bit combinational partial-sum stage.

---
 rtl/mult_pkg.sv | 41 ++++
 rtl/mult_pp_gen.sv | 33 +++
 rtl/multiplier_pl_tree.sv | 97 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared helpers and stage sideband type for the pipelined tree multiplier.
package mult_pkg;

   // Ceiling log2, used for tree depth.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Floor log2, used to find the tree level of a heap node index.
   function automatic int flog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((64'd1 << i) <= 64'(v)) r = i;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // One partial-product stage plus one stage per tree level.
   function automatic int lat_of(input int w);
      return clog2(w) + 1;
   endfunction

   localparam int DEF_WIDTH = 4;
   localparam int DEF_LAT   = lat_of(DEF_WIDTH);

   typedef struct packed {
      logic valid;
      logic sgn;
   } sb_t;

endpackage

// File: rtl/mult_pp_gen.sv
// Combinational partial-product generator; signed mode negates the MSB row.
module mult_pp_gen
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               sgn_i,
   output logic [2*WIDTH-1:0] pp_o [WIDTH]
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0] ext;
   logic [PW-1:0] term;

   always_comb begin
      ext  = sgn_i ? {{WIDTH{a_i[WIDTH-1]}}, a_i}
                   : {{WIDTH{1'b0}}, a_i};
      term = '0;
      for (int i = 0; i < WIDTH; i++) begin
         term = b_i[i] ? (ext << i) : '0;
         // In two's complement the top multiplier bit weighs -2^(W-1).
         if (sgn_i && (i == WIDTH - 1)) begin
            pp_o[i] = -term;
         end else begin
            pp_o[i] = term;
         end
      end
   end

endmodule

// File: rtl/multiplier_pl_tree.sv
// Fully pipelined multiplier: registered partial products reduced by a
// registered pairwise adder tree, with a single global stall.
module multiplier_pl_tree
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               busy
);

   localparam int LAT = lat_of(WIDTH);
   localparam int LVL = LAT - 1;
   localparam int PW  = 2 * WIDTH;
   localparam int NN  = 2 * WIDTH;

   if (WIDTH < 4 || WIDTH > 16 || !is_pow2(WIDTH)) begin : g_bad_width
      $error("multiplier_pl_tree: WIDTH must be a power of two in 4..16");
   end

   logic [PW-1:0] pp     [WIDTH];
   // Heap layout: leaves at WIDTH..2*WIDTH-1, root at 1.
   logic [PW-1:0] node_q [1:NN-1];
   logic [PW-1:0] sum_d  [1:WIDTH-1];
   sb_t           sb_q   [0:LVL];
   sb_t           sb_d   [0:LVL];
   logic          stall;
   logic          adv;

   mult_pp_gen #(
      .WIDTH (WIDTH)
   ) u_pp_gen (
      .a_i   (in_a),
      .b_i   (in_b),
      .sgn_i (in_signed),
      .pp_o  (pp)
   );

   for (genvar k = 1; k < WIDTH; k++) begin : g_add
      assign sum_d[k] = node_q[2*k] + node_q[2*k+1];
   end

   assign out_valid = sb_q[LVL].valid;
   assign out_p     = node_q[1];
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign adv       = ~stall;

   always_comb begin
      sb_d[0].valid = in_valid;
      sb_d[0].sgn   = in_signed & in_valid;
      for (int s = 1; s <= LVL; s++) begin
         sb_d[s] = sb_q[s-1];
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s <= LVL; s++) begin
         busy = busy | sb_q[s].valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s <= LVL; s++) begin
            sb_q[s] <= '0;
         end
         for (int k = 1; k < NN; k++) begin
            node_q[k] <= '0;
         end
      end else if (adv) begin
         sb_q <= sb_d;
         if (in_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
               node_q[WIDTH+i] <= pp[i];
            end
         end
         // A node loads only when the stage feeding it holds valid data.
         for (int k = 1; k < WIDTH; k++) begin
            if (sb_q[LVL-flog2(k)-1].valid) begin
               node_q[k] <= sum_d[k];
            end
         end
      end
   end

endmodule
